hex_scan_display: RTL and testbench
===================================

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clocks each digit is lit (legal range >= 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; 1 inverts segment, dp_out and digit_sel.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  scanning enable.
REQ-007 SHALL have port load  in  1  one-cycle strobe capturing value/dp/lz_en.
REQ-008 SHALL have port value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 least significant.
REQ-009 SHALL have port dp  in  NUM_DIGITS  decimal-point request per digit.
REQ-010 SHALL have port lz_en  in  1  leading-zero suppression request.
REQ-011 SHALL have port segment  out  7  segments a..g on bits 6..0.
REQ-012 SHALL have port dp_out  out  1  decimal point of the lit digit.
REQ-013 SHALL have port digit_sel  out  NUM_DIGITS  one-hot digit enable.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Function
REQ-015 Segment encoding SHALL be (a..g, active-high before polarity) 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; blank=0000000.
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 while enable=1, wrapping to 0; terminal count is a "tick".
REQ-017 Digit index SHALL advance on each tick, NUM_DIGITS-1 wrapping to 0.
REQ-018 frame_done SHALL pulse for exactly the cycle after a tick with index NUM_DIGITS-1 (the frame boundary).
REQ-019 load SHALL capture value, dp, lz_en into a pending register and set a pending flag; a later load before the boundary SHALL overwrite pending.
REQ-020 At the frame boundary, the display register SHALL take pending contents if the flag is set, then clear the flag; no mid-frame change of displayed data.
REQ-021 load coincident with the boundary SHALL transfer the new value/dp/lz_en directly to the display register and leave the flag clear.
REQ-022 With display lz_en=1, digit i (i>0) SHALL be blank (segments and dp off) when nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be suppressed.
REQ-023 segment, dp_out, digit_sel SHALL be registered, reflecting the current index one cycle after the index changes.
REQ-024 enable=0 SHALL hold prescaler and index, drive all outputs inactive, suppress frame_done; load and pending transfer rules remain active only at boundaries (no boundaries occur while disabled).
REQ-025 Re-asserting enable SHALL resume from the held prescaler and index.
REQ-026 Inactive level SHALL be 0 for segment, dp_out, digit_sel when ACTIVE_LOW=0 and 1 when ACTIVE_LOW=1; frame_done always active-high.

Reset
REQ-027 rst_n=0 SHALL immediately clear prescaler, index, pending flag, pending and display registers (value 0, dp 0, lz_en 0).
REQ-028 During reset, segment, dp_out, digit_sel SHALL be at inactive level and frame_done 0.
REQ-029 After release, first digit displayed SHALL be digit 0 showing "0" (if enable=1) from the second clock edge.
REQ-030 Reset asserted mid-frame SHALL discard pending data; no transfer occurs on release.

Verification (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-031 Reset release, enable=1, no load -> digit_sel 0001,0010,0100,1000 each 4 cycles, segment 1111110 throughout, frame_done pulse every 16 cycles.
REQ-032 load value=16'h12AF mid-frame -> current frame unchanged; after next frame_done digits 0..3 show F,A,2,1 (1000111,1110111,1101101,0110000).
REQ-033 load 16'h0042 with lz_en=1, dp=4'b0001 -> digits 3,2 blank, digit1=4, digit0=2 with dp_out=1; value 16'h0000 lz_en=1 -> only digit 0 shows 0.
REQ-034 Two loads (16'h1111 then 16'h2222) in one frame, plus load 16'h3333 exactly at boundary cycle -> displayed frame shows 3333, pending flag clear, no 2222 frame.
REQ-035 enable dropped mid-slot on digit 2 for 10 cycles -> outputs all 0, no frame_done; on re-enable digit 2 resumes for the remaining slot cycles.
REQ-036 ACTIVE_LOW=1, rst_n pulsed low asynchronously mid-frame -> outputs go all-ones immediately, pending load discarded, display returns to 0000.

Source files
------------

// File: rtl/hex_scan_display_if.sv
// ============================================================================
// Module : hex_scan_display_if
// Brief  : Control/data bundle between a host and the hex scan display.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface hex_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp;
    logic                      lz_en;
    logic [6:0]                segment;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     digit_sel;
    logic                      frame_done;

    modport master (
        output enable, load, value, dp, lz_en,
        input  segment, dp_out, digit_sel, frame_done
    );

    modport slave (
        input  enable, load, value, dp, lz_en,
        output segment, dp_out, digit_sel, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/hex_scan_display.sv
// ============================================================================
// Module : hex_scan_display
// Brief  : Multiplexed 7-segment hex display scanner with frame-synchronous
//          data update and leading-zero suppression.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hex_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hex_scan_display_if.slave  bus
);
    localparam int   c_PRE_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int   c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic c_POL   = (ACTIVE_LOW != 0);

    logic [c_PRE_W-1:0]      r_presc;
    logic [c_IDX_W-1:0]      r_idx;
    logic                    r_pend_flag;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_lz;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_disp_lz;
    logic [6:0]              r_seg;
    logic                    r_dp_out;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_idx_last;
    logic                    w_boundary;
    logic [3:0]              w_nib;
    logic                    w_dp_req;
    logic [NUM_DIGITS-1:0]   w_allz;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [6:0]              w_seg;

    assign w_tick     = bus.enable && (r_presc == c_PRE_W'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == c_IDX_W'(NUM_DIGITS - 1));
    assign w_boundary = w_tick && w_idx_last;

    // Digit data selection; w_allz[i] means nibbles i..top are all zero.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_req = 1'b0;
        w_sel    = '0;
        w_blank  = 1'b0;
        w_allz   = '0;
        w_allz[NUM_DIGITS-1] = (r_disp_val[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            w_allz[i] = (r_disp_val[4*i +: 4] == 4'h0) && w_allz[i+1];
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nib    = r_disp_val[4*i +: 4];
                w_dp_req = r_disp_dp[i];
                w_sel[i] = 1'b1;
                w_blank  = r_disp_lz && (i != 0) && w_allz[i];
            end
        end
    end

    always_comb begin
        w_seg = 7'b0000000;
        if (!w_blank) begin
            case (w_nib)
                4'h0: w_seg = 7'b1111110;
                4'h1: w_seg = 7'b0110000;
                4'h2: w_seg = 7'b1101101;
                4'h3: w_seg = 7'b1111001;
                4'h4: w_seg = 7'b0110011;
                4'h5: w_seg = 7'b1011011;
                4'h6: w_seg = 7'b1011111;
                4'h7: w_seg = 7'b1110000;
                4'h8: w_seg = 7'b1111111;
                4'h9: w_seg = 7'b1111011;
                4'hA: w_seg = 7'b1110111;
                4'hB: w_seg = 7'b0011111;
                4'hC: w_seg = 7'b1001110;
                4'hD: w_seg = 7'b0111101;
                4'hE: w_seg = 7'b1001111;
                default: w_seg = 7'b1000111;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (bus.enable) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) begin
                    r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                end
            end
            r_frame_done <= w_boundary;
        end
    end

    // Displayed data only changes at a frame boundary; a load on that same
    // cycle bypasses the pending stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_flag <= 1'b0;
            r_pend_val  <= '0;
            r_pend_dp   <= '0;
            r_pend_lz   <= 1'b0;
            r_disp_val  <= '0;
            r_disp_dp   <= '0;
            r_disp_lz   <= 1'b0;
        end else if (w_boundary) begin
            if (bus.load) begin
                r_disp_val <= bus.value;
                r_disp_dp  <= bus.dp;
                r_disp_lz  <= bus.lz_en;
            end else if (r_pend_flag) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
                r_disp_lz  <= r_pend_lz;
            end
            r_pend_flag <= 1'b0;
        end else if (bus.load) begin
            r_pend_val  <= bus.value;
            r_pend_dp   <= bus.dp;
            r_pend_lz   <= bus.lz_en;
            r_pend_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg    <= {7{c_POL}};
            r_dp_out <= c_POL;
            r_sel    <= {NUM_DIGITS{c_POL}};
        end else if (!bus.enable) begin
            r_seg    <= {7{c_POL}};
            r_dp_out <= c_POL;
            r_sel    <= {NUM_DIGITS{c_POL}};
        end else begin
            r_seg    <= w_seg ^ {7{c_POL}};
            r_dp_out <= (w_dp_req && !w_blank) ^ c_POL;
            r_sel    <= w_sel ^ {NUM_DIGITS{c_POL}};
        end
    end

    assign bus.segment    = r_seg;
    assign bus.dp_out     = r_dp_out;
    assign bus.digit_sel  = r_sel;
    assign bus.frame_done = r_frame_done;
endmodule

`default_nettype wire

// File: tb/tb_hex_scan_display.sv
// ============================================================================
// Module : tb_hex_scan_display
// Brief  : Self-checking bench for hex_scan_display (4 digits, 4 clk/slot).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hex_scan_display;
    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } obs_t;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic        lz;
        logic [3:0]  blank;
        logic [3:0]  edp;
    } vec_t;

    typedef struct {
        int          at;
        logic [15:0] val;
        logic [3:0]  dp;
        logic        lz;
    } ld_t;

    logic clk;
    logic rst_n;
    logic rst_al;
    int   n_tests;
    int   n_fail;
    obs_t sb[$];
    ld_t  ldq[$];
    vec_t vecs[10];

    hex_scan_display_if #(.NUM_DIGITS(4)) bus ();
    hex_scan_display_if #(.NUM_DIGITS(4)) bus_al ();

    hex_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hex_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut_al (
        .clk   (clk),
        .rst_n (rst_al),
        .bus   (bus_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic obs_t sample(input bit al);
        obs_t o;
        if (al) o = '{bus_al.digit_sel, bus_al.segment, bus_al.dp_out, bus_al.frame_done};
        else    o = '{bus.digit_sel, bus.segment, bus.dp_out, bus.frame_done};
        return o;
    endfunction

    task automatic chk(input string nm, input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                     nm, got.sel, got.seg, got.dp, got.fd, exp.sel, exp.seg, exp.dp, exp.fd);
        end
    endtask

    // Enters on the negedge following a frame boundary (or reset release).
    task automatic run_frame(input string nm, input logic [15:0] ev, input logic [3:0] edp,
                             input logic [3:0] eblank, input int gap_at, input int gap_len,
                             input bit skip1);
        int   total;
        int   p;
        int   d;
        obs_t e;
        total = 16 + gap_len;
        for (int t = 1; t <= total; t++) begin
            if (gap_len > 0 && t > gap_at && t <= gap_at + gap_len) begin
                e = '0;
            end else begin
                p = (gap_len > 0 && t > gap_at + gap_len) ? t - gap_len : t;
                d = (p - 1) / 4;
                e.sel = 4'(1 << d);
                e.seg = eblank[d] ? 7'b0000000 : glyph(ev[4*d +: 4]);
                e.dp  = edp[d];
                e.fd  = (p == 16);
            end
            sb.push_back(e);
        end
        for (int t = 1; t <= total; t++) begin
            @(negedge clk);
            e = sb.pop_front();
            if (!(skip1 && t == 1)) chk($sformatf("%s t%0d", nm, t), sample(1'b0), e);
            bus.load = 1'b0;
            foreach (ldq[k]) begin
                if (ldq[k].at == t) begin
                    bus.load  = 1'b1;
                    bus.value = ldq[k].val;
                    bus.dp    = ldq[k].dp;
                    bus.lz_en = ldq[k].lz;
                end
            end
            bus.enable = !(gap_len > 0 && t >= gap_at && t < gap_at + gap_len);
        end
        ldq.delete();
    endtask

    function automatic obs_t al_exp(input int t);
        obs_t e;
        int   d;
        d     = ((t - 1) / 4) % 4;
        e.sel = ~4'(1 << d);
        e.seg = ~7'b1111110;
        e.dp  = 1'b1;
        e.fd  = (t % 16 == 0);
        return e;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{16'h0000, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[1] = '{16'h12AF, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[2] = '{16'h0042, 4'b0001, 1'b1, 4'b1100, 4'b0001};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, 4'b1110, 4'b0000};
        vecs[4] = '{16'h0000, 4'b1010, 1'b0, 4'b0000, 4'b1010};
        vecs[5] = '{16'h30D0, 4'b0000, 1'b1, 4'b0000, 4'b0000};
        vecs[6] = '{16'h0100, 4'b1111, 1'b1, 4'b1000, 4'b0111};
        vecs[7] = '{16'h89E6, 4'b0100, 1'b0, 4'b0000, 4'b0100};
        vecs[8] = '{16'h7B54, 4'b0000, 1'b1, 4'b0000, 4'b0000};
        vecs[9] = '{16'hC3F0, 4'b1000, 1'b1, 4'b0000, 4'b1000};

        rst_n = 1'b0;  rst_al = 1'b0;
        bus.enable = 1'b1;    bus.load = 1'b0;    bus.value = '0;    bus.dp = '0;    bus.lz_en = 1'b0;
        bus_al.enable = 1'b1; bus_al.load = 1'b0; bus_al.value = '0; bus_al.dp = '0; bus_al.lz_en = 1'b0;

        repeat (2) begin
            @(negedge clk);
            chk("reset_main", sample(1'b0), '0);
            chk("reset_al", sample(1'b1), '{4'hF, 7'h7F, 1'b1, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            if (v < 9) ldq.push_back('{5, vecs[v+1].val, vecs[v+1].dp, vecs[v+1].lz});
            run_frame($sformatf("vec%0d", v), vecs[v].val, vecs[v].edp, vecs[v].blank, 0, 0, v == 0);
        end

        // Two mid-frame loads, then a third on the boundary cycle itself.
        ldq.push_back('{3,  16'h1111, 4'b0000, 1'b0});
        ldq.push_back('{8,  16'h2222, 4'b0000, 1'b0});
        ldq.push_back('{15, 16'h3333, 4'b0000, 1'b0});
        run_frame("coalesce", vecs[9].val, vecs[9].edp, vecs[9].blank, 0, 0, 1'b0);
        run_frame("gap", 16'h3333, 4'b0000, 4'b0000, 10, 10, 1'b0);
        run_frame("no2222", 16'h3333, 4'b0000, 4'b0000, 0, 0, 1'b0);

        @(negedge clk);
        rst_al = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            chk($sformatf("al_run t%0d", t), sample(1'b1), al_exp(t));
            bus_al.load  = (t == 4);
            bus_al.value = 16'h5555;
        end
        @(posedge clk);
        #2 rst_al = 1'b0;
        #1 chk("al_async_rst", sample(1'b1), '{4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        rst_al = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            chk($sformatf("al_after t%0d", t), sample(1'b1), al_exp(t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
